// File: rtl/fp_divsqrt_queue_pkg.sv
// Shared APU cluster types: FP widths, status-bit indices and the queued request word.
package apu_cluster_package;
  localparam int FP_WIDTH   = 32;
  localparam int TAG_WIDTH  = 4;
  localparam int RND_WIDTH  = 3;
  localparam int PREC_WIDTH = 6;

  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  typedef struct packed {
    logic [FP_WIDTH-1:0]   opa;
    logic [FP_WIDTH-1:0]   opb;
    logic                  sqrt;
    logic [RND_WIDTH-1:0]  rnd;
    logic [PREC_WIDTH-1:0] prec;
    logic [TAG_WIDTH-1:0]  tag;
  } fp_req_t;
endpackage

// File: rtl/fp_divsqrt_queue_if.sv
// Request/result handshake bundle of the div/sqrt queue; slave is the queue side.
interface fp_divsqrt_queue_if
  import apu_cluster_package::*;
#(parameter int DEPTH = 2) ();
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [FP_WIDTH-1:0]   in_opa_i;
  logic [FP_WIDTH-1:0]   in_opb_i;
  logic                  in_sqrt_i;
  logic [RND_WIDTH-1:0]  in_rnd_i;
  logic [PREC_WIDTH-1:0] in_prec_i;
  logic [TAG_WIDTH-1:0]  in_tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [FP_WIDTH-1:0]   out_res_o;
  logic [4:0]            out_status_o;
  logic [TAG_WIDTH-1:0]  out_tag_o;
  logic [OCC_W-1:0]      occupancy_o;
  logic                  busy_o;

  modport slave (
    input  flush_i, in_valid_i, in_opa_i, in_opb_i, in_sqrt_i, in_rnd_i, in_prec_i, in_tag_i,
           out_ready_i,
    output in_ready_o, out_valid_o, out_res_o, out_status_o, out_tag_o, occupancy_o, busy_o
  );

  modport master (
    output flush_i, in_valid_i, in_opa_i, in_opb_i, in_sqrt_i, in_rnd_i, in_prec_i, in_tag_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, out_res_o, out_status_o, out_tag_o, occupancy_o, busy_o
  );
endinterface

// File: rtl/fp_divsqrt_core.sv
// Iterative FP32 div/sqrt core: radix-2, 26 steps, single-cycle Done; subnormals flush to zero.
module fp_divsqrt_core
  import apu_cluster_package::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_start,
  input  logic                  sqrt_start,
  input  logic [FP_WIDTH-1:0]   opa,
  input  logic [FP_WIDTH-1:0]   opb,
  input  logic [1:0]            rm,
  input  logic [PREC_WIDTH-1:0] prec,
  output logic                  ready,
  output logic                  done,
  output logic [FP_WIDTH-1:0]   result,
  output logic [4:0]            status
);
  localparam int          ITERS = 26;
  localparam logic [31:0] QNAN  = 32'h7fc0_0000;

  logic                  iter, fin, start;
  logic [4:0]            cnt;
  logic                  sqrt_op, sign, spec;
  logic [31:0]           spec_res;
  logic [4:0]            spec_flags;
  logic signed [9:0]     exp_q, ue, exp_div;
  logic [1:0]            rm_q;
  logic [PREC_WIDTH-1:0] prec_q;
  logic [23:0]           dvsr;
  logic [51:0]           rad;
  logic [27:0]           rem, rem_sh, trial, rem_nx;
  logic [25:0]           quo;
  logic                  qbit;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  assign {ea, fa} = opa[30:0];
  assign {eb, fb} = opb[30:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hff) && (fa == '0);
  assign b_inf  = (eb == 8'hff) && (fb == '0);
  assign a_nan  = (ea == 8'hff) && (fa != '0);
  assign b_nan  = (eb == 8'hff) && (fb != '0);
  assign a_snan = a_nan & ~fa[22];
  assign b_snan = b_nan & ~fb[22];

  assign ready   = ~iter & ~fin;
  assign done    = fin;
  assign start   = (div_start | sqrt_start) & ready;
  assign ue      = $signed({2'b00, ea}) - 10'sd127;
  assign exp_div = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  logic        s_spec, s_sign;
  logic [31:0] s_res;
  logic [4:0]  s_flags;
  always_comb begin
    s_sign  = sqrt_start ? opa[31] : opa[31] ^ opb[31];
    s_spec  = 1'b1;
    s_res   = QNAN;
    s_flags = '0;
    if (sqrt_start) begin
      if (a_nan)        s_flags[NV] = a_snan;
      else if (a_zero)  s_res = {opa[31], 31'd0};
      else if (opa[31]) s_flags[NV] = 1'b1;
      else if (a_inf)   s_res = 32'h7f80_0000;
      else              s_spec = 1'b0;
    end else begin
      if (a_nan || b_nan)                          s_flags[NV] = a_snan | b_snan;
      else if ((a_inf && b_inf) || (a_zero && b_zero)) s_flags[NV] = 1'b1;
      else if (a_inf || b_zero) begin
        s_res       = {s_sign, 8'hff, 23'd0};
        s_flags[DZ] = b_zero & ~a_inf;
      end
      else if (a_zero || b_inf) s_res = {s_sign, 31'd0};
      else                      s_spec = 1'b0;
    end
  end

  // sqrt retires two radicand bits per step against trial 4*root+1
  always_comb begin
    if (sqrt_op) begin
      rem_sh = {rem[25:0], rad[51:50]};
      trial  = {quo, 2'b01};
    end else begin
      rem_sh = rem;
      trial  = {4'd0, dvsr};
    end
    qbit   = (rem_sh >= trial);
    rem_nx = qbit ? rem_sh - trial : rem_sh;
    if (!sqrt_op) rem_nx = rem_nx << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter <= 1'b0;
      fin  <= 1'b0;
      cnt  <= '0;
    end else begin
      fin <= 1'b0;
      if (start) begin
        iter <= 1'b1;
        cnt  <= 5'(ITERS);
      end else if (iter) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          iter <= 1'b0;
          fin  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      sqrt_op    <= sqrt_start;
      sign       <= s_sign;
      spec       <= s_spec;
      spec_res   <= s_res;
      spec_flags <= s_flags;
      rm_q       <= rm;
      prec_q     <= prec;
      quo        <= '0;
      exp_q      <= sqrt_start ? (ue >>> 1) + 10'sd127 : exp_div;
      dvsr       <= {1'b1, fb};
      rad        <= ue[0] ? {1'b1, fa, 28'd0} : {2'b01, fa, 27'd0};
      rem        <= sqrt_start ? 28'd0 : {4'd0, 1'b1, fa};
    end else if (iter) begin
      quo <= {quo[24:0], qbit};
      rem <= rem_nx;
      rad <= {rad[49:0], 2'b00};
    end
  end

  logic              norm, guard, sticky, inc, sat, lead_unused;
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic signed [9:0] e_fin;
  logic [22:0]       frac, pmask;
  assign lead_unused = mant_r[23];
  always_comb begin
    norm   = quo[25];
    mant   = norm ? quo[25:2] : quo[24:1];
    guard  = norm ? quo[1] : quo[0];
    sticky = (norm & quo[0]) | (rem != '0);
    case (rm_q)
      2'd0:    inc = guard & (sticky | mant[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = sign & (guard | sticky);
      default: inc = ~sign & (guard | sticky);
    endcase
    mant_r = {1'b0, mant} + 25'(inc);
    e_fin  = exp_q - (norm ? 10'sd0 : 10'sd1) + (mant_r[24] ? 10'sd1 : 10'sd0);
    frac   = mant_r[24] ? 23'd0 : mant_r[22:0];
    // reduced precision keeps only the top prec-1 fraction bits
    pmask  = (prec_q == '0 || prec_q >= 6'd24) ? '1 : ~(23'h7f_ffff >> (prec_q - 6'd1));
    sat    = (rm_q == 2'd1) || (rm_q == 2'd2 && !sign) || (rm_q == 2'd3 && sign);
    result = {sign, e_fin[7:0], frac & pmask};
    status = '0;
    if (spec) begin
      result = spec_res;
      status = spec_flags;
    end else if (e_fin >= 10'sd255) begin
      result     = sat ? {sign, 8'hfe, 23'h7f_ffff} : {sign, 8'hff, 23'd0};
      status[OF] = 1'b1;
      status[NX] = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      result     = {sign, 31'd0};
      status[UF] = 1'b1;
      status[NX] = 1'b1;
    end else begin
      status[NX] = guard | sticky;
    end
  end
endmodule

// File: rtl/fp_req_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module fp_req_fifo #(
  parameter type DATA_T = logic,
  parameter int  DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  DATA_T                      wdata,
  output DATA_T                      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  DATA_T         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/fp_divsqrt_queue.sv
// Queued front end for the div/sqrt core: in-order FIFO, one op in flight, held result slot.
module fp_divsqrt_queue
  import apu_cluster_package::*;
#(parameter int DEPTH = 2) (
  input logic           clk_i,
  input logic           rst_i,
  fp_divsqrt_queue_if.slave io
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  fp_req_t              wreq, head;
  logic                 push, pop, full, empty;
  logic [CNT_W-1:0]     count;
  logic                 core_ready, core_done;
  logic [FP_WIDTH-1:0]  core_res;
  logic [4:0]           core_status;
  logic                 div_start, sqrt_start, dispatch, slot_free;
  logic [TAG_WIDTH-1:0] flight_tag;
  logic                 status_unused;

  assign io.in_ready_o  = ~full & ~io.flush_i;
  assign push           = io.in_valid_i & io.in_ready_o;
  assign pop            = dispatch;
  assign slot_free      = ~io.out_valid_o | io.out_ready_i;
  assign io.occupancy_o = count;
  assign io.busy_o      = (state == BUSY);
  assign status_unused  = ^{core_status[NV], core_status[NX], head.rnd[RND_WIDTH-1:2]};
  assign wreq = '{opa: io.in_opa_i, opb: io.in_opb_i, sqrt: io.in_sqrt_i,
                  rnd: io.in_rnd_i, prec: io.in_prec_i, tag: io.in_tag_i};

  fp_req_fifo #(.DATA_T(fp_req_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (io.flush_i),
    .push  (push),
    .pop   (pop),
    .wdata (wreq),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  fp_divsqrt_core u_core (
    .clk        (clk_i),
    .rst_n      (~rst_i),
    .div_start  (div_start),
    .sqrt_start (sqrt_start),
    .opa        (head.opa),
    .opb        (head.opb),
    .rm         (head.rnd[1:0]),
    .prec       (head.prec),
    .ready      (core_ready),
    .done       (core_done),
    .result     (core_res),
    .status     (core_status)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // issuing only into a free or draining slot means Done never finds it occupied
  always_comb begin
    state_nx   = state;
    dispatch   = 1'b0;
    div_start  = 1'b0;
    sqrt_start = 1'b0;
    case (state)
      IDLE: if (!empty && core_ready && !io.flush_i && slot_free) begin
        dispatch   = 1'b1;
        div_start  = ~head.sqrt;
        sqrt_start = head.sqrt;
        state_nx   = BUSY;
      end
      BUSY: if (core_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         flight_tag <= '0;
    else if (dispatch) flight_tag <= head.tag;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      io.out_valid_o  <= 1'b0;
      io.out_res_o    <= '0;
      io.out_status_o <= '0;
      io.out_tag_o    <= '0;
    end else if (state == BUSY && core_done) begin
      io.out_valid_o  <= 1'b1;
      io.out_res_o    <= core_res;
      io.out_status_o <= {1'b0, core_status[DZ], core_status[OF], core_status[UF], 1'b0};
      io.out_tag_o    <= flight_tag;
    end else if (io.out_valid_o && io.out_ready_i) begin
      io.out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_divsqrt_queue.sv
// Directed bench for fp_divsqrt_queue: div, sqrt, div-by-zero, back-pressure, flush, reset mid-op.
module tb_fp_divsqrt_queue;
  import apu_cluster_package::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   starts = 0;

  fp_divsqrt_queue_if #(.DEPTH(2)) io ();
  fp_divsqrt_queue #(.DEPTH(2)) dut (.clk_i(clk), .rst_i(rst), .io(io));

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && (dut.div_start || dut.sqrt_start)) starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sq,
                      input logic [3:0] tag);
    int n = 0;
    io.in_opa_i   = a;
    io.in_opb_i   = b;
    io.in_sqrt_i  = sq;
    io.in_rnd_i   = '0;
    io.in_prec_i  = '0;
    io.in_tag_i   = tag;
    io.in_valid_i = 1'b1;
    while (!io.in_ready_o && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    io.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!io.out_valid_o && n < 80) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(io.out_valid_o), 64'd1);
  endtask

  task automatic drain();
    io.out_ready_i = 1'b1;
    @(negedge clk);
    io.out_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io.flush_i = 1'b0; io.in_valid_i = 1'b0; io.out_ready_i = 1'b0;
    io.in_opa_i = '0; io.in_opb_i = '0; io.in_sqrt_i = 1'b0;
    io.in_rnd_i = '0; io.in_prec_i = '0; io.in_tag_i = '0;
    tick(2);
    chk("rst_in_ready",  64'(io.in_ready_o),   64'd1);
    chk("rst_out_valid", 64'(io.out_valid_o),  64'd0);
    chk("rst_busy",      64'(io.busy_o),       64'd0);
    chk("rst_occ",       64'(io.occupancy_o),  64'd0);
    chk("rst_res",       64'(io.out_res_o),    64'd0);
    chk("rst_status",    64'(io.out_status_o), 64'd0);
    chk("rst_tag",       64'(io.out_tag_o),    64'd0);
    rst = 1'b0;
    tick(1);

    // single div 6/2
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd3);
    chk("div_start_t1", 64'(dut.div_start), 64'd1);
    chk("div_occ_t1",   64'(io.occupancy_o), 64'd1);
    wait_out("div");
    chk("div_res",    64'(io.out_res_o),    64'h4040_0000);
    chk("div_status", 64'(io.out_status_o), 64'd0);
    chk("div_tag",    64'(io.out_tag_o),    64'd3);
    drain();
    chk("div_drained", 64'(io.out_valid_o), 64'd0);

    // sqrt 4
    push(32'h4080_0000, 32'h0, 1'b1, 4'd5);
    chk("sqrt_start_t1", 64'(dut.sqrt_start), 64'd1);
    wait_out("sqrt");
    chk("sqrt_res",    64'(io.out_res_o),    64'h4000_0000);
    chk("sqrt_status", 64'(io.out_status_o), 64'd0);
    chk("sqrt_tag",    64'(io.out_tag_o),    64'd5);
    drain();

    // 1/0
    push(32'h3F80_0000, 32'h0, 1'b0, 4'd7);
    wait_out("dz");
    chk("dz_res",    64'(io.out_res_o),    64'h7F80_0000);
    chk("dz_status", 64'(io.out_status_o), 64'b01000);
    chk("dz_tag",    64'(io.out_tag_o),    64'd7);
    drain();

    // fill with consumer stalled
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd1);
    push(32'h4080_0000, 32'h0,         1'b1, 4'd2);
    push(32'h3F80_0000, 32'h0,         1'b0, 4'd3);
    chk("fill_occ",      64'(io.occupancy_o), 64'd2);
    chk("fill_in_ready", 64'(io.in_ready_o),  64'd0);
    wait_out("fill1");
    chk("fill1_tag", 64'(io.out_tag_o), 64'd1);
    chk("fill1_res", 64'(io.out_res_o), 64'h4040_0000);
    tick(30);
    chk("fill_hold_starts", 64'(starts),         64'd4);
    chk("fill_hold_busy",   64'(io.busy_o),      64'd0);
    chk("fill_hold_tag",    64'(io.out_tag_o),   64'd1);
    chk("fill_hold_occ",    64'(io.occupancy_o), 64'd2);
    drain();
    wait_out("fill2");
    chk("fill2_tag", 64'(io.out_tag_o), 64'd2);
    chk("fill2_res", 64'(io.out_res_o), 64'h4000_0000);
    drain();
    wait_out("fill3");
    chk("fill3_tag",    64'(io.out_tag_o),    64'd3);
    chk("fill3_res",    64'(io.out_res_o),    64'h7F80_0000);
    chk("fill3_status", 64'(io.out_status_o), 64'b01000);
    drain();
    chk("fill_in_ready_back", 64'(io.in_ready_o), 64'd1);

    // flush with 2 queued and 1 in flight
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd8);
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd9);
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd10);
    chk("flush_pre_occ", 64'(io.occupancy_o), 64'd2);
    io.flush_i = 1'b1;
    #1;
    chk("flush_in_ready", 64'(io.in_ready_o), 64'd0);
    @(negedge clk);
    io.flush_i = 1'b0;
    chk("flush_occ",  64'(io.occupancy_o), 64'd0);
    chk("flush_busy", 64'(io.busy_o),      64'd1);
    wait_out("flush");
    chk("flush_tag", 64'(io.out_tag_o), 64'd8);
    drain();
    tick(40);
    chk("flush_starts", 64'(starts),         64'd7);
    chk("flush_idle",   64'(io.busy_o),      64'd0);
    chk("flush_nores",  64'(io.out_valid_o), 64'd0);

    // reset while BUSY
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd11);
    tick(5);
    chk("rmid_busy", 64'(io.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_valid", 64'(io.out_valid_o), 64'd0);
    chk("rmid_busy0", 64'(io.busy_o),      64'd0);
    chk("rmid_occ",   64'(io.occupancy_o), 64'd0);
    chk("rmid_tag",   64'(io.out_tag_o),   64'd0);
    tick(40);
    chk("rmid_no_late", 64'(io.out_valid_o), 64'd0);
    push(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd12);
    wait_out("post_rst");
    chk("post_rst_res", 64'(io.out_res_o), 64'h4040_0000);
    chk("post_rst_tag", 64'(io.out_tag_o), 64'd12);
    drain();
    chk("total_starts", 64'(starts), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_divsqrt_queue.md
# fp_divsqrt_queue

Queued, back-pressured front end for the shared iterative FP div/sqrt core in the APU cluster. It buffers up to DEPTH tagged requests, with per-request rounding mode and precision control. It issues them one at a time to the core, captures each single-cycle core result into a held output slot, and presents it with a valid/ready handshake. Requests and results carry the 5-bit status vector {NV,DZ,OF,UF,NX}, and a flush drops queued, unissued work.

## Interface
- FP_WIDTH, 32 (apu_cluster_package): operand/result width
- TAG_WIDTH, 4: request tag width, min 1
- RND_WIDTH, 3: rounding-mode field; core uses bits [1:0]
- PREC_WIDTH, 6: precision-control field passed to core
- DEPTH, 2: request-FIFO entries, power of two, min 2
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all queued (unissued) requests
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
- in_opa_i, in_opb_i  in  FP_WIDTH  operands (sqrt uses opa)
- in_sqrt_i  in  1  1 = sqrt, 0 = div (opa/opb)
- in_rnd_i  in  RND_WIDTH  rounding mode
- in_prec_i  in  PREC_WIDTH  precision control
- in_tag_i  in  TAG_WIDTH  request tag
- out_valid_o  out  1  result slot holds a result
- out_ready_i  in  1  consumer takes result when out_valid_o & out_ready_i
- out_res_o  out  FP_WIDTH  result
- out_status_o  out  5  {NV=0, DZ, OF, UF, NX=0}
- out_tag_o  out  TAG_WIDTH  tag of the request that produced it
- occupancy_o  out  $clog2(DEPTH+1)  queued entries
- busy_o  out  1  an operation is in flight in the core

## Operation
- Engine FSM states: IDLE, BUSY.
- Dispatch in IDLE when all four hold:
  - FIFO is non-empty.
  - Core Ready is high.
  - flush_i is low.
  - The output slot is empty or is being drained this cycle.
- On dispatch:
  - Drive Div_start or Sqrt_start (per the head entry's sqrt bit) for exactly one cycle, with the head operands, rnd[1:0] and prec.
  - Pop the head.
  - Latch its tag into the in-flight tag register.
  - Go to BUSY.
- In BUSY, on core Done:
  - Capture result, DZ, OF and UF into the output slot together with the in-flight tag.
  - Set out_valid_o and go to IDLE.
- Core Done while IDLE is ignored.
- The dispatch condition guarantees the output slot is free when Done arrives. The core cannot be stalled.
- Output slot holds its value stable until the handshake completes. It clears on handshake unless refilled in the same cycle.
- in_ready_o = !full & !flush_i. Push and pop in the same cycle are allowed when the FIFO is not full. Occupancy is unchanged on push+pop.
- flush_i empties the FIFO in that cycle and suppresses dispatch. An in-flight op still completes and is delivered.
- Order: results leave in request-acceptance order (single engine, in-order FIFO).
- Core reset is driven as ~rst_i.

## Timing
- Reset values:
  - in_ready_o=1, out_valid_o=0, busy_o=0, occupancy_o=0.
  - out_res_o, out_status_o and out_tag_o are all 0.
  - FSM in IDLE.
- Reset mid-operation: everything above is restored the next cycle. The FIFO contents and the in-flight op are lost, and no result is delivered.
- Request accepted at cycle t → earliest start pulse at t+1 (FIFO is registered, no bypass).
- Core Done at cycle d → out_valid_o high from d+1.
- Back-to-back: the next start can occur in the cycle after the Done cycle, provided the output slot is free or draining.
- Throughput is one op per (core latency + 1) cycles while out_ready_i stays high.
- out_valid_o low with out_ready_i high: no effect.

## Structure
- Package apu_cluster_package gets:
  - The status-bit index constants (NV=4, DZ=3, OF=2, UF=1, NX=0).
  - A request typedef: packed struct {opa, opb, sqrt, rnd, prec, tag}, used as the FIFO word.
- Sub-module: fp_req_fifo, a generic synchronous FIFO (DATA_T, DEPTH) with full, empty, count and flush. It uses the same clock and synchronous active-high reset.
- The top holds the FSM, the in-flight tag register, the output slot and the core instance.

## Test plan
- **Single div:** opa=0x40C00000, opb=0x40000000, tag=3, rnd=0.
  - Expect: start pulse at t+1, then out_res_o=0x40400000, status=0, tag=3.
- **Sqrt:** opa=0x40800000, sqrt=1.
  - Expect: res=0x40000000.
- **Divide by zero:** opa=0x3F800000, opb=0.
  - Expect: res=0x7F800000, status=5'b01000.
- **Fill and back-pressure:**
  - Stimulus: push 3 ops with tags 1, 2, 3 (DEPTH=2, one issued), with out_ready_i held 0.
  - Expect: in_ready_o drops when occupancy_o=2 and no second start until the slot is drained; results then emerge with tags 1, 2, 3 in order.
- **Flush:**
  - Stimulus: 2 queued, 1 in flight; assert flush_i for 1 cycle.
  - Expect: occupancy_o=0 next cycle, only the in-flight result is delivered, and no further start pulses occur.
- **Reset mid-op:**
  - Stimulus: rst_i for 1 cycle while BUSY.
  - Expect: out_valid_o=0, busy_o=0 and occupancy_o=0 next cycle; a late core Done is ignored, and a new request then completes normally.
